// File: rtl/audio_bus_slave_pkg.sv
// Shared constants for the audio bus slave: register map, STATUS bit layout and
// the read FSM state encoding.
package audio_bus_slave_pkg;

  localparam logic [2:0] ADDR_I2C_DATA_AUDIO = 3'd0;
  localparam logic [2:0] ADDR_DAC_AUDIO      = 3'd1;
  localparam logic [2:0] ADDR_ADC_AUDIO      = 3'd2;
  localparam logic [2:0] ADDR_STATUS_AUDIO   = 3'd3;
  localparam logic [2:0] ADDR_CTRL_AUDIO     = 3'd4;

  localparam int STAT_I2C_BUSY    = 0;
  localparam int STAT_DAC_FULL    = 1;
  localparam int STAT_ADC_FULL    = 2;
  localparam int STAT_ADC_EMPTY   = 3;
  localparam int STAT_DAC_EMPTY   = 4;
  localparam int STAT_ADC_OVF     = 5;
  localparam int STAT_I2C_COLL    = 6;
  localparam int STAT_ADC_OCC_LSB = 8;
  localparam int STAT_DAC_OCC_LSB = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_CAPT = 2'd1;
  localparam logic [1:0] ST_RD_DONE = 2'd2;

  // Bit 24 is the launch strobe, so it never reads back as set.
  function automatic logic [31:0] i2c_readback(input logic [31:0] stored);
    return {stored[31:25], 1'b0, stored[23:0]};
  endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock FIFO with full/empty/count; a pop frees a slot for a push in
// the same cycle, so a full FIFO can accept while it drains.
module audio_sync_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer width equals log2(DEPTH), so natural overflow wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/audio_bus_slave.sv
// Memory-mapped audio control slave: WM8731 I2C launch register, DAC/ADC sample
// FIFOs, sticky status flags and an ADC-data interrupt.
module audio_bus_slave
  import audio_bus_slave_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        irq,
  output logic        i2c_start,
  output logic [23:0] i2c_packet,
  input  logic        i2c_busy,
  output logic [31:0] dac_sample,
  output logic        dac_valid,
  input  logic        dac_ready,
  input  logic [31:0] adc_sample,
  input  logic        adc_valid
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              wr_acc, rd_acc, capt;
  logic [1:0]        state_q, state_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [31:0]       i2c_data_q, i2c_data_d;
  logic [23:0]       i2c_packet_q, i2c_packet_d;
  logic              i2c_start_q, i2c_start_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  logic              adc_ovf_q, adc_ovf_d;
  logic              i2c_coll_q, i2c_coll_d;
  logic [31:0]       status, rd_mux;

  logic              dac_push, dac_pop, dac_full, dac_empty, dac_stall;
  logic [CNT_W-1:0]  dac_count;
  logic              adc_pop, adc_full, adc_empty;
  logic [CNT_W-1:0]  adc_count;
  logic [31:0]       adc_head;

  // Read together with write counts as a write.
  assign wr_acc = chipselect & write;
  assign rd_acc = chipselect & read & ~write;
  assign capt   = (state_q == ST_RD_CAPT) & rd_acc;

  assign dac_push  = wr_acc & (address == ADDR_DAC_AUDIO);
  assign dac_pop   = ~dac_empty & dac_ready;
  assign dac_stall = dac_push & dac_full & ~dac_ready;
  assign adc_pop   = capt & (address == ADDR_ADC_AUDIO);

  audio_sync_fifo #(.DATA_W(32), .DEPTH(FIFO_DEPTH)) u_dac_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (dac_push),
    .pop   (dac_pop),
    .din   (writedata),
    .dout  (dac_sample),
    .full  (dac_full),
    .empty (dac_empty),
    .count (dac_count)
  );

  audio_sync_fifo #(.DATA_W(32), .DEPTH(FIFO_DEPTH)) u_adc_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (adc_valid),
    .pop   (adc_pop),
    .din   (adc_sample),
    .dout  (adc_head),
    .full  (adc_full),
    .empty (adc_empty),
    .count (adc_count)
  );

  always_comb begin
    status                               = '0;
    status[STAT_I2C_BUSY]                = i2c_busy;
    status[STAT_DAC_FULL]                = dac_full;
    status[STAT_ADC_FULL]                = adc_full;
    status[STAT_ADC_EMPTY]               = adc_empty;
    status[STAT_DAC_EMPTY]               = dac_empty;
    status[STAT_ADC_OVF]                 = adc_ovf_q;
    status[STAT_I2C_COLL]                = i2c_coll_q;
    status[STAT_ADC_OCC_LSB +: 8]        = 8'(adc_count);
    status[STAT_DAC_OCC_LSB +: 8]        = 8'(dac_count);
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_I2C_DATA_AUDIO: rd_mux = i2c_readback(i2c_data_q);
      ADDR_ADC_AUDIO:      rd_mux = adc_empty ? 32'd0 : adc_head;
      ADDR_STATUS_AUDIO:   rd_mux = status;
      ADDR_CTRL_AUDIO:     rd_mux = {31'd0, irq_en_q};
      default:             rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    readdata_d   = readdata_q;
    i2c_data_d   = i2c_data_q;
    i2c_packet_d = i2c_packet_q;
    i2c_start_d  = 1'b0;
    irq_en_d     = irq_en_q;
    adc_ovf_d    = adc_ovf_q;
    i2c_coll_d   = i2c_coll_q;
    irq_d        = irq_en_q & ~adc_empty;

    // A read dropped in RD_CAPT falls back to IDLE without capture or pop.
    case (state_q)
      ST_IDLE:    if (rd_acc) state_d = ST_RD_CAPT;
      ST_RD_CAPT: state_d = rd_acc ? ST_RD_DONE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (capt) readdata_d = rd_mux;

    // Clear-on-read first so a set event in the same cycle wins.
    if (capt && (address == ADDR_STATUS_AUDIO)) begin
      adc_ovf_d  = 1'b0;
      i2c_coll_d = 1'b0;
    end
    if (adc_valid && adc_full && !adc_pop) adc_ovf_d = 1'b1;

    if (wr_acc && (address == ADDR_I2C_DATA_AUDIO)) begin
      i2c_data_d = writedata;
      if (writedata[24]) begin
        if (i2c_busy) begin
          i2c_coll_d = 1'b1;
        end else begin
          i2c_start_d  = 1'b1;
          i2c_packet_d = writedata[23:0];
        end
      end
    end

    if (wr_acc && (address == ADDR_CTRL_AUDIO)) irq_en_d = writedata[0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      readdata_q   <= '0;
      i2c_data_q   <= '0;
      i2c_packet_q <= '0;
      i2c_start_q  <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
      adc_ovf_q    <= 1'b0;
      i2c_coll_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      readdata_q   <= readdata_d;
      i2c_data_q   <= i2c_data_d;
      i2c_packet_q <= i2c_packet_d;
      i2c_start_q  <= i2c_start_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      adc_ovf_q    <= adc_ovf_d;
      i2c_coll_q   <= i2c_coll_d;
    end
  end

  assign readdata    = readdata_q;
  assign i2c_start   = i2c_start_q;
  assign i2c_packet  = i2c_packet_q;
  assign irq         = irq_q;
  assign dac_valid   = ~dac_empty;
  assign waitrequest = ~Reset & (rd_acc ? (state_q != ST_RD_DONE) : dac_stall);

endmodule

// File: tb/tb_audio_bus_slave.sv
// Testbench for audio_bus_slave: register table, directed corner sequences and
// randomized FIFO traffic against a queue-based reference model.
module tb_audio_bus_slave;
  import audio_bus_slave_pkg::*;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [2:0]  address;
  logic        chipselect, read, write;
  logic [31:0] writedata, readdata;
  logic        waitrequest, irq, i2c_start;
  logic [23:0] i2c_packet;
  logic        i2c_busy;
  logic [31:0] dac_sample;
  logic        dac_valid, dac_ready;
  logic [31:0] adc_sample;
  logic        adc_valid;

  int n_checks = 0;
  int n_fail   = 0;

  audio_bus_slave #(.FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .irq(irq), .i2c_start(i2c_start),
    .i2c_packet(i2c_packet), .i2c_busy(i2c_busy), .dac_sample(dac_sample),
    .dac_valid(dac_valid), .dac_ready(dac_ready), .adc_sample(adc_sample),
    .adc_valid(adc_valid)
  );

  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        do_wr;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  logic [31:0] dq [$];
  logic [31:0] aq [$];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(int asz, int dsz, logic ovf, logic coll, logic busy);
    logic [31:0] s;
    s        = '0;
    s[0]     = busy;
    s[1]     = (dsz == DEPTH);
    s[2]     = (asz == DEPTH);
    s[3]     = (asz == 0);
    s[4]     = (dsz == 0);
    s[5]     = ovf;
    s[6]     = coll;
    s[15:8]  = asz[7:0];
    s[23:16] = dsz[7:0];
    return s;
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!waitrequest) begin ok = 1'b1; break; end
      @(posedge Clk); #1;
    end
    if (ok) tick();
    check("wr_accepted", 32'(ok), 32'd1);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output int lat);
    logic ok;
    ok = 1'b0; lat = 0; d = '0;
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!waitrequest) begin ok = 1'b1; d = readdata; break; end
      @(posedge Clk); #1;
      lat++;
    end
    if (ok) tick();
    check("rd_completed", 32'(ok), 32'd1);
    chipselect = 1'b0; read = 1'b0;
  endtask

  initial begin
    logic [31:0] d, s;
    int          lat;
    logic        ovf;

    vecs[0]  = '{1'b1, ADDR_I2C_DATA_AUDIO, 32'h00AB_CDEF, ADDR_I2C_DATA_AUDIO, 32'h00AB_CDEF};
    vecs[1]  = '{1'b1, ADDR_I2C_DATA_AUDIO, 32'hFFFF_FFFF, ADDR_I2C_DATA_AUDIO, 32'hFEFF_FFFF};
    vecs[2]  = '{1'b1, ADDR_CTRL_AUDIO,     32'hFFFF_FFFF, ADDR_CTRL_AUDIO,     32'h0000_0001};
    vecs[3]  = '{1'b1, ADDR_CTRL_AUDIO,     32'h0000_0000, ADDR_CTRL_AUDIO,     32'h0000_0000};
    vecs[4]  = '{1'b1, 3'd5,                32'h1234_5678, 3'd5,                32'h0000_0000};
    vecs[5]  = '{1'b1, 3'd7,                32'hFFFF_FFFF, 3'd7,                32'h0000_0000};
    vecs[6]  = '{1'b1, ADDR_STATUS_AUDIO,   32'hFFFF_FFFF, ADDR_STATUS_AUDIO,   32'h0000_0018};
    vecs[7]  = '{1'b1, ADDR_ADC_AUDIO,      32'h5555_5555, ADDR_ADC_AUDIO,      32'h0000_0000};
    vecs[8]  = '{1'b0, 3'd0,                32'h0,         ADDR_STATUS_AUDIO,   32'h0000_0018};
    vecs[9]  = '{1'b1, ADDR_I2C_DATA_AUDIO, 32'h0000_0000, ADDR_I2C_DATA_AUDIO, 32'h0000_0000};
    vecs[10] = '{1'b1, 3'd6,                32'hDEAD_BEEF, ADDR_I2C_DATA_AUDIO, 32'h0000_0000};

    Reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0; address = '0;
    writedata = '0; i2c_busy = 1'b0; dac_ready = 1'b0; adc_sample = '0; adc_valid = 1'b0;
    tick(); tick();
    check("rst_readdata",    readdata,           32'd0);
    check("rst_waitrequest", 32'(waitrequest),   32'd0);
    check("rst_i2c_start",   32'(i2c_start),     32'd0);
    check("rst_i2c_packet",  32'(i2c_packet),    32'd0);
    check("rst_irq",         32'(irq),           32'd0);
    check("rst_dac_valid",   32'(dac_valid),     32'd0);
    Reset = 1'b0;
    tick();

    // Register map table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].waddr, vecs[i].wdata);
      bus_read(vecs[i].raddr, d, lat);
      check($sformatf("vec%0d", i), d, vecs[i].exp);
    end

    // I2C launch with serializer idle
    bus_write(ADDR_I2C_DATA_AUDIO, 32'h0134_1E00);
    check("i2c_start_pulse", 32'(i2c_start),  32'd1);
    check("i2c_packet",      32'(i2c_packet), 32'h0034_1E00);
    tick();
    check("i2c_start_once",  32'(i2c_start),  32'd0);
    bus_read(ADDR_I2C_DATA_AUDIO, d, lat);
    check("i2c_readback", d, 32'h0034_1E00);
    check("read_latency", 32'(lat), 32'd2);

    // I2C launch while busy: collision
    i2c_busy = 1'b1;
    bus_write(ADDR_I2C_DATA_AUDIO, 32'h0134_1E00);
    check("i2c_busy_no_start", 32'(i2c_start), 32'd0);
    tick();
    check("i2c_busy_no_start2", 32'(i2c_start), 32'd0);
    bus_read(ADDR_STATUS_AUDIO, s, lat);
    check("coll_set", s, exp_status(0, 0, 1'b0, 1'b1, 1'b1));
    bus_read(ADDR_STATUS_AUDIO, s, lat);
    check("coll_cleared", 32'(s[6]), 32'd0);
    i2c_busy = 1'b0;

    // DAC FIFO: fifth write stalls until a pop frees a slot
    for (int k = 0; k < 4; k++) bus_write(ADDR_DAC_AUDIO, 32'hD000_0000 + k);
    chipselect = 1'b1; write = 1'b1; address = ADDR_DAC_AUDIO; writedata = 32'hD000_0004;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("dac_stall", 32'(waitrequest), 32'd1);
      @(posedge Clk); #1;
    end
    dac_ready = 1'b1;
    #1;
    check("dac_stall_release", 32'(waitrequest), 32'd0);
    check("dac_head0", dac_sample, 32'hD000_0000);
    tick();
    chipselect = 1'b0; write = 1'b0; dac_ready = 1'b0;
    bus_read(ADDR_STATUS_AUDIO, s, lat);
    check("dac_full_status", s, exp_status(0, 4, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= 4; k++) begin
      check("dac_valid_drain", 32'(dac_valid), 32'd1);
      check("dac_order", dac_sample, 32'hD000_0000 + k);
      dac_ready = 1'b1;
      tick();
      dac_ready = 1'b0;
    end
    check("dac_empty", 32'(dac_valid), 32'd0);

    // ADC FIFO ordering and empty read
    adc_valid = 1'b1; adc_sample = 32'hA5A5_0001; tick();
    adc_sample = 32'hA5A5_0002; tick();
    adc_valid = 1'b0;
    bus_read(ADDR_ADC_AUDIO, d, lat);
    check("adc_rd1", d, 32'hA5A5_0001);
    check("adc_rd_latency", 32'(lat), 32'd2);
    bus_read(ADDR_ADC_AUDIO, d, lat);
    check("adc_rd2", d, 32'hA5A5_0002);
    bus_read(ADDR_ADC_AUDIO, d, lat);
    check("adc_rd_empty", d, 32'd0);
    bus_read(ADDR_STATUS_AUDIO, s, lat);
    check("adc_empty_bit", 32'(s[3]), 32'd1);

    // ADC overflow and interrupt
    for (int k = 0; k < 6; k++) begin
      adc_valid = 1'b1; adc_sample = 32'hB000_0000 + k; tick();
    end
    adc_valid = 1'b0;
    bus_read(ADDR_STATUS_AUDIO, s, lat);
    check("adc_overflow_status", s, exp_status(4, 0, 1'b1, 1'b0, 1'b0));
    bus_write(ADDR_CTRL_AUDIO, 32'h1);
    check("irq_delayed", 32'(irq), 32'd0);
    tick();
    check("irq_set", 32'(irq), 32'd1);

    // Reset during RD_CAPT of an ADC read
    chipselect = 1'b1; read = 1'b1; address = ADDR_ADC_AUDIO;
    tick();
    check("in_rd_capt", 32'(dut.state_q), 32'(ST_RD_CAPT));
    Reset = 1'b1; chipselect = 1'b0; read = 1'b0;
    tick();
    Reset = 1'b0;
    #1;
    check("rst_rd_wait", 32'(waitrequest), 32'd0);
    check("rst_rd_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("rst_rd_readdata", readdata, 32'd0);
    tick();
    check("rst_rd_irq", 32'(irq), 32'd0);
    bus_read(ADDR_STATUS_AUDIO, s, lat);
    check("rst_rd_status", s, exp_status(0, 0, 1'b0, 1'b0, 1'b0));

    // Random DAC write/pop traffic against a queue model
    dq.delete();
    for (int c = 0; c < 300; c++) begin
      logic        w, r, stall;
      logic [31:0] wd;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 3) == 0);
      wd = $urandom;
      chipselect = w; write = w; read = 1'b0; address = ADDR_DAC_AUDIO; writedata = wd; dac_ready = r;
      #1;
      stall = w && (dq.size() == DEPTH) && !r;
      check("rnd_dac_valid", 32'(dac_valid), 32'(dq.size() > 0));
      if (dq.size() > 0) check("rnd_dac_head", dac_sample, dq[0]);
      check("rnd_dac_wait", 32'(waitrequest), 32'(stall));
      if (r && dq.size() > 0) void'(dq.pop_front());
      if (w && !stall) dq.push_back(wd);
      @(posedge Clk); #1;
    end
    chipselect = 1'b0; write = 1'b0; dac_ready = 1'b0;

    // Random ADC pushes and reads against a queue model
    aq.delete();
    ovf = 1'b0;
    for (int it = 0; it < 60; it++) begin
      int np, op;
      np = $urandom_range(0, 3);
      for (int j = 0; j < np; j++) begin
        logic [31:0] smp;
        smp = $urandom;
        adc_valid = 1'b1; adc_sample = smp;
        tick();
        if (aq.size() < DEPTH) aq.push_back(smp);
        else ovf = 1'b1;
      end
      adc_valid = 1'b0;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        logic [31:0] e;
        e = (aq.size() > 0) ? aq.pop_front() : 32'd0;
        bus_read(ADDR_ADC_AUDIO, d, lat);
        check("rnd_adc_read", d, e);
      end else if (op == 1) begin
        bus_read(ADDR_STATUS_AUDIO, s, lat);
        check("rnd_status", s, exp_status(aq.size(), dq.size(), ovf, 1'b0, 1'b0));
        ovf = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
